// File: rtl/xor_serial_sched_if.sv
// xor_serial_sched_if: requester, result and shared-XOR-cell signals of xor_serial_sched
interface xor_serial_sched_if #(
    parameter int W = 8
);
    logic         s0_valid, s0_ready, s1_valid, s1_ready;
    logic [W-1:0] s0_a, s0_b, s1_a, s1_b;
    logic         m_valid, m_ready, m_id;
    logic [W-1:0] m_y;
    logic         xa, xb, xy, busy;
    modport slave (
        input  s0_valid, s0_a, s0_b, s1_valid, s1_a, s1_b, m_ready, xy,
        output s0_ready, s1_ready, m_valid, m_y, m_id, xa, xb, busy
    );
    modport master (
        output s0_valid, s0_a, s0_b, s1_valid, s1_a, s1_b, m_ready, xy,
        input  s0_ready, s1_ready, m_valid, m_y, m_id, xa, xb, busy
    );
endinterface

// File: rtl/xor_serial_sched.sv
// xor_serial_sched: round-robin scheduler streaming two requesters' operands
// LSB-first through one shared external 1-bit XOR cell, returning tagged results
module xor_serial_sched #(
    parameter int W = 8
) (
    input logic               clk,
    input logic               rst_n,
    xor_serial_sched_if.slave bus
);
    localparam int CW = $clog2(W) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t        state_q, state_d;
    logic [W-1:0]  sa_q, sa_d, sb_q, sb_d, ry_q, ry_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          id_q, id_d, last_q, last_d;
    logic          gnt, rdy0, rdy1;
    // on contention the requester not served last wins
    assign gnt  = (bus.s0_valid && bus.s1_valid) ? ~last_q : bus.s1_valid;
    assign rdy0 = (state_q == IDLE) && bus.s0_valid && !gnt;
    assign rdy1 = (state_q == IDLE) && bus.s1_valid && gnt;
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        ry_d    = ry_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (rdy0 || rdy1) begin
                state_d = SHIFT;
                sa_d    = gnt ? bus.s1_a : bus.s0_a;
                sb_d    = gnt ? bus.s1_b : bus.s0_b;
                id_d    = gnt;
                cnt_d   = '0;
                ry_d    = '0;
            end
            SHIFT: begin
                ry_d  = (ry_q >> 1) | (W'(bus.xy) << (W - 1));
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                cnt_d = cnt_q + CW'(1);
                state_d = (cnt_q == CW'(W - 1)) ? DONE : SHIFT;
            end
            DONE: if (bus.m_ready) begin
                state_d = IDLE;
                last_d  = id_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            ry_q    <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            ry_q    <= ry_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end
    assign bus.s0_ready = rdy0;
    assign bus.s1_ready = rdy1;
    assign bus.xa       = (state_q == SHIFT) && sa_q[0];
    assign bus.xb       = (state_q == SHIFT) && sb_q[0];
    assign bus.m_valid  = (state_q == DONE);
    assign bus.m_y      = ry_q;
    assign bus.m_id     = id_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_xor_serial_sched.sv
// tb_xor_serial_sched: vector table, directed corner sequences and random traffic
// checked against a cycle-level transaction model of the scheduler
module tb_xor_serial_sched;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    xor_serial_sched_if #(.W(W)) b8 ();
    xor_serial_sched_if #(.W(1)) b1 ();
    assign b8.xy = b8.xa ^ b8.xb;
    assign b1.xy = b1.xa ^ b1.xb;
    xor_serial_sched #(.W(W)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    xor_serial_sched #(.W(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    typedef struct {bit v0; bit v1; bit r0; bit r1;} vec_t;
    vec_t tbl[4];
    int errors = 0;
    int checks = 0;
    bit m_idle = 1'b1, m_last = 1'b1, m_id = 1'b0;
    int m_cyc = 0;
    logic [W-1:0] m_a, m_b;
    logic [W-1:0] hs_y[$];
    bit hs_id[$];
    logic [W-1:0] xa_seq, xb_seq;
    int xn = W;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // model: idle, or m_cyc cycles into an op (m_cyc == W means result offered)
    task automatic step();
        bit g, r0, r1, done, ea, eb;
        #1;
        g    = (b8.s0_valid && b8.s1_valid) ? !m_last : b8.s1_valid;
        r0   = m_idle && b8.s0_valid && !g;
        r1   = m_idle && b8.s1_valid && g;
        done = !m_idle && m_cyc == W;
        ea = 1'b0;
        eb = 1'b0;
        if (!m_idle && m_cyc < W) begin
            ea = m_a[m_cyc];
            eb = m_b[m_cyc];
        end
        chk("s0_ready", b8.s0_ready, r0);
        chk("s1_ready", b8.s1_ready, r1);
        chk("busy", b8.busy, !m_idle);
        chk("m_valid", b8.m_valid, done);
        chk("xa", b8.xa, ea);
        chk("xb", b8.xb, eb);
        if (done) begin
            chk("m_y", b8.m_y, m_a ^ m_b);
            chk("m_id", b8.m_id, m_id);
        end
        if (b8.busy && !b8.m_valid && xn < W) begin
            xa_seq[xn] = b8.xa;
            xb_seq[xn] = b8.xb;
            xn++;
        end
        if (!rst_n) begin
            m_idle = 1'b1;
            m_last = 1'b1;
        end else if (r0 || r1) begin
            m_idle = 1'b0;
            m_cyc  = 0;
            m_id   = r1;
            m_a    = r1 ? b8.s1_a : b8.s0_a;
            m_b    = r1 ? b8.s1_b : b8.s0_b;
        end else if (!m_idle && m_cyc < W) begin
            m_cyc++;
        end else if (done && b8.m_ready) begin
            m_idle = 1'b1;
            m_last = m_id;
            hs_y.push_back(m_a ^ m_b);
            hs_id.push_back(m_id);
        end
        @(posedge clk);
        #1;
        if (rst_n && r0) b8.s0_valid = 1'b0;
        if (rst_n && r1) b8.s1_valid = 1'b0;
    endtask
    task automatic req(input bit n, input logic [W-1:0] a, input logic [W-1:0] b);
        if (n) begin
            b8.s1_valid = 1'b1; b8.s1_a = a; b8.s1_b = b;
        end else begin
            b8.s0_valid = 1'b1; b8.s0_a = a; b8.s0_b = b;
        end
    endtask
    task automatic w1_op(input bit n, input bit a, input bit b, input bit y);
        b1.s0_valid = !n; b1.s1_valid = n;
        b1.s0_a = a; b1.s0_b = b; b1.s1_a = a; b1.s1_b = b;
        b1.m_ready = 1'b1;
        #1;
        chk("w1_ready", n ? b1.s1_ready : b1.s0_ready, 1);
        @(posedge clk); #1;
        b1.s0_valid = 1'b0; b1.s1_valid = 1'b0;
        chk("w1_shift_busy", b1.busy, 1);
        chk("w1_shift_xa", b1.xa, a);
        chk("w1_shift_xb", b1.xb, b);
        chk("w1_shift_mvalid", b1.m_valid, 0);
        @(posedge clk); #1;
        chk("w1_mvalid", b1.m_valid, 1);
        chk("w1_m_y", b1.m_y, y);
        chk("w1_m_id", b1.m_id, n);
        @(posedge clk); #1;
        chk("w1_idle", b1.busy, 0);
    endtask
    initial begin
        tbl[0] = '{0, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 0};
        tbl[2] = '{0, 1, 0, 1};
        tbl[3] = '{1, 1, 1, 0};
        {b8.s0_valid, b8.s1_valid, b8.m_ready} = '0;
        {b8.s0_a, b8.s0_b, b8.s1_a, b8.s1_b} = '0;
        {b1.s0_valid, b1.s1_valid, b1.m_ready, b1.s0_a, b1.s0_b, b1.s1_a, b1.s1_b} = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", b8.m_valid, 0);
        chk("rst_m_y", b8.m_y, 0);
        chk("rst_m_id", b8.m_id, 0);
        chk("rst_xa_xb", {b8.xa, b8.xb}, 0);
        chk("rst_busy", b8.busy, 0);
        chk("rst_w1_busy", {b1.busy, b1.m_valid, b1.m_y}, 0);
        for (int i = 0; i < 4; i++) begin
            b8.s0_valid = tbl[i].v0;
            b8.s1_valid = tbl[i].v1;
            #1;
            chk($sformatf("grant_tbl%0d_r0", i), b8.s0_ready, tbl[i].r0);
            chk($sformatf("grant_tbl%0d_r1", i), b8.s1_ready, tbl[i].r1);
        end
        b8.s0_valid = 1'b0;
        b8.s1_valid = 1'b0;
        rst_n = 1'b1;
        req(0, 8'hFF, 8'h00);
        req(1, 8'h3C, 8'h3C);
        b8.m_ready = 1'b1;
        repeat (2 * (W + 2) + 2) step();
        chk("cont_count", hs_y.size(), 2);
        chk("cont_first_id", hs_id[0], 0);
        chk("cont_first_y", hs_y[0], 8'hFF);
        chk("cont_second_id", hs_id[1], 1);
        chk("cont_second_y", hs_y[1], 8'h00);
        hs_y.delete(); hs_id.delete();
        req(0, 8'h11, 8'h22);
        req(1, 8'h44, 8'h88);
        repeat (2 * (W + 2) + 2) step();
        chk("cont2_count", hs_y.size(), 2);
        chk("cont2_order", {hs_id[0], hs_id[1]}, 2'b01);
        chk("cont2_ys", {hs_y[0], hs_y[1]}, {8'h33, 8'hCC});
        hs_y.delete(); hs_id.delete();
        xn = 0;
        req(0, 8'hA5, 8'h0F);
        repeat (W + 3) step();
        chk("single_xa_seq", xa_seq, 8'hA5);
        chk("single_xb_seq", xb_seq, 8'h0F);
        chk("single_y", hs_y[0], 8'hAA);
        chk("single_id", hs_id[0], 0);
        hs_y.delete(); hs_id.delete();
        b8.m_ready = 1'b0;
        req(0, 8'h5A, 8'hC3);
        step();
        req(1, 8'h0F, 8'hF0);
        for (int i = 0; i < 3 * W && !b8.m_valid; i++) step();
        chk("bp_wait_valid", b8.m_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_y", b8.m_y, 8'h99);
            chk("bp_hold_id", b8.m_id, 0);
            chk("bp_s1_ready", b8.s1_ready, 0);
            step();
        end
        b8.m_ready = 1'b1;
        step();
        #1;
        chk("bp_s1_accept", b8.s1_ready, 1);
        repeat (W + 3) step();
        chk("bp_order", {hs_id[0], hs_id[1]}, 2'b01);
        chk("bp_s1_y", hs_y[1], 8'hFF);
        hs_y.delete(); hs_id.delete();
        req(1, 8'hAB, 8'hCD);
        repeat (3) step();
        rst_n = 1'b0;
        b8.s1_valid = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (W + 3) step();
        chk("midrst_no_result", hs_y.size(), 0);
        req(1, 8'h12, 8'h34);
        repeat (W + 3) step();
        chk("midrst_y", hs_y[0], 8'h26);
        chk("midrst_id", hs_id[0], 1);
        for (int i = 0; i < 400; i++) begin
            if (!b8.s0_valid && $urandom_range(0, 3) == 0) req(0, W'($urandom), W'($urandom));
            if (!b8.s1_valid && $urandom_range(0, 3) == 0) req(1, W'($urandom), W'($urandom));
            b8.m_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        w1_op(0, 1'b1, 1'b1, 1'b0);
        w1_op(1, 1'b1, 1'b0, 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/xor_serial_sched.md
# xor_serial_sched

- Bit-serial XOR scheduler that shares one external 1-bit 2-input XOR gate cell between two requesters.
- Each request carries two W-bit operands. The block arbitrates round-robin between the requesters and streams operand bits LSB-first through the shared cell.
- It assembles the W-bit result and returns it on a single tagged output channel with valid/ready backpressure.
- It sits between the requesting datapath blocks and the gate cell, whose inputs and output are wired to xa, xb and xy.

## Interface

Parameters:
- W, 8, operand/result width; legal range 1..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- s0_valid  input  1  requester 0 has an operand pair.
- s0_ready  output  1  requester 0 transfer accepted this cycle.
- s0_a, s0_b  input  W  requester 0 operands.
- s1_valid, s1_ready, s1_a, s1_b  same as s0_*, for requester 1.
- m_valid  output  1  result available.
- m_ready  input  1  consumer accepts the result.
- m_y  output  W  result, equal to a XOR b.
- m_id  output  1  index of the requester that owns m_y.
- xa, xb  output  1  operand bits driven to the shared XOR cell.
- xy  input  1  output of the shared XOR cell; combinational from xa and xb.
- busy  output  1  high whenever state is not IDLE.

## Operation

- The state machine has three states: IDLE, SHIFT, DONE.
- Internal registers:
  - sa, sb: W-bit operand shift registers.
  - ry: W-bit result register.
  - cnt: counter, width ceil(log2(W))+1.
  - id: owner of the current operation.
  - last: last requester served; resets to 1, so requester 0 wins the first tie.

IDLE:
- Grant selection:
  - If only one sN_valid is high, grant that requester.
  - If both are high, grant the requester not equal to last.
- sN_ready is combinational: it is 1 only for the granted requester, only in IDLE, and only while its valid is high.
- On a transfer (sN_valid && sN_ready):
  - sa <= sN_a, sb <= sN_b, id <= N, cnt <= 0, ry <= 0.
  - Next state is SHIFT.
- The requester not granted keeps its ready low and must hold valid and data; it is served after the current operation completes.

SHIFT:
- xa = sa[0], xb = sb[0].
- On each edge:
  - ry <= {xy, ry[W-1:1]}.
  - sa and sb shift right by one.
  - cnt increments.
- When cnt == W-1, the edge completes the last bit and next state is DONE.
- After W SHIFT cycles, ry[i] = a[i] ^ b[i].

DONE:
- m_valid = 1, m_y = ry, m_id = id. All three hold stable until m_ready.
- On m_valid && m_ready: last <= id, next state is IDLE.

Outside SHIFT:
- xa = xb = 0.
- xy is ignored.

Source-side rules:
- A requester must not drop valid or change its operands before its ready.
- Violations are not detected.

## Timing

Reset:
- While rst_n is low at an edge: state <= IDLE, last <= 1, and sa, sb, ry, cnt, id are cleared.
- Output values during and after reset:
  - m_valid, m_y, m_id, xa, xb, busy are all 0.
  - s0_ready and s1_ready are 0 unless the corresponding valid is high.
- Reset mid-operation discards the in-flight request. No m_valid is produced for it, and the requester must re-present it.

Latency and throughput:
- For a transfer at edge T: SHIFT occupies cycles T+1 .. T+W, and m_valid rises in the cycle after edge T+W.
- With m_ready held high, the next transfer happens at the earliest one cycle after the m handshake edge. Throughput is 1 operation per W+2 cycles.

Boundary conditions:
- W=1: exactly one SHIFT cycle.
- No request is accepted while busy, so simultaneous sN_valid and m_ready never collide.
- Contention alternates strictly: 0, 1, 0, 1, ...

## Test plan

1. Reset: rst_n low for 2 cycles with both valids low.
   -> All outputs 0, busy 0; first contended grant goes to requester 0.
2. Single op, W=8: s0 a=0xA5, b=0x0F, m_ready=1.
   -> xa sequence 1,0,1,0,0,1,0,1; xb sequence 1,1,1,1,0,0,0,0.
   -> m_valid rises 9 cycles after the transfer edge, with m_y=0xAA, m_id=0.
3. Contention: s0 (0xFF, 0x00) and s1 (0x3C, 0x3C) valid in the same cycle.
   -> s0 is served first: m_y=0xFF, m_id=0.
   -> s1 is then accepted: m_y=0x00, m_id=1.
   -> A second simultaneous pair is served 0, then 1.
4. Backpressure: m_ready low for 5 cycles after m_valid, with s1 valid throughout.
   -> m_y and m_id stay stable, s1_ready stays 0, busy stays 1.
   -> s1 is accepted one cycle after the handshake.
5. Reset mid-op: rst_n low during the 3rd SHIFT cycle.
   -> m_valid never asserts for that op.
   -> A re-presented s1 (0x12, 0x34) yields m_y=0x26, m_id=1.
6. W=1 build: s0 a=1, b=1, then s1 a=1, b=0.
   -> Results are 0 and 1, each with m_valid rising 2 cycles after its transfer edge.
